// File: rtl/svm_seq_mac.sv
// Sequential SVM decision engine: one MAC per cycle over N_features, then a
// one-cycle result pulse, repeated for N_decisions pairwise decisions per sample.
module svm_seq_mac #(
  parameter int N_features  = 4,
  parameter int inputWidth  = 4,
  parameter int weightWidth = 8,
  parameter int biasWidth   = 12,
  parameter int N_decisions = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [inputWidth*N_features-1:0]  features,
  input  logic [weightWidth*N_features-1:0] weight,
  input  logic [biasWidth-1:0]              bia,
  output logic                              busy,
  output logic                              svmready,
  output logic                              w_class
);

  localparam int accWidth = inputWidth + weightWidth + $clog2(N_features) + 2;
  localparam int IDXW     = (N_features > 1) ? $clog2(N_features) : 1;
  localparam int DECW     = $clog2(N_decisions + 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                              r_state;
  state_t                              w_next;
  logic [inputWidth*N_features-1:0]    r_feat;
  logic [IDXW-1:0]                     r_idx;
  logic [DECW-1:0]                     r_dec;
  logic signed [accWidth-1:0]          r_acc;
  logic                                r_class;

  logic [inputWidth-1:0]               w_feat;
  logic [weightWidth-1:0]              w_wsel;
  logic [accWidth-1:0]                 w_fext;
  logic [accWidth-1:0]                 w_wext;
  logic signed [accWidth-1:0]          w_prod;
  logic signed [accWidth-1:0]          w_acc_sum;
  logic signed [accWidth-1:0]          w_bias_ext;
  logic                                w_last;
  logic                                w_dec_done;

  // Operand selection and signed arithmetic at accumulator width.
  // Both operands are extended to accWidth before multiplying, so the low
  // accWidth bits of the product are the exact two's-complement result.
  always_comb begin
    w_feat     = r_feat[r_idx*inputWidth +: inputWidth];
    w_wsel     = weight[r_idx*weightWidth +: weightWidth];
    w_fext     = {{(accWidth-inputWidth){1'b0}}, w_feat};
    w_wext     = {{(accWidth-weightWidth){w_wsel[weightWidth-1]}}, w_wsel};
    w_prod     = w_fext * w_wext;
    w_acc_sum  = r_acc + w_prod;
    w_bias_ext = {{(accWidth-biasWidth){bia[biasWidth-1]}}, bia};
    w_last     = (r_idx == IDXW'(N_features - 1));
    w_dec_done = ((r_dec + 1'b1) == DECW'(N_decisions));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = MAC;
      MAC:     if (w_last)   w_next = DONE;
      DONE:    w_next = w_dec_done ? IDLE : MAC;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: feature latch, accumulator, index, decision counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_dec   <= '0;
      r_class <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_feat <= features;
            r_idx  <= '0;
            r_acc  <= w_bias_ext;
            r_dec  <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_sum;
          r_idx <= r_idx + 1'b1;
          if (w_last) r_class <= ~w_acc_sum[accWidth-1];
        end
        DONE: begin
          r_dec <= r_dec + 1'b1;
          r_idx <= '0;
          r_acc <= w_bias_ext;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  assign busy     = (r_state != IDLE);
  assign svmready = (r_state == DONE);
  assign w_class  = r_class;

endmodule

// File: doc/svm_seq_mac.md
SVM_SEQ_MAC -- requirements
Module: svm_seq_mac

Interface
REQ-001 SHALL take parameter N_features, default 4; number of features per sample and MAC steps per decision.
REQ-002 SHALL take parameter inputWidth, default 4; unsigned feature width.
REQ-003 SHALL take parameter weightWidth, default 8; signed weight width.
REQ-004 SHALL take parameter biasWidth, default 12; signed bias width.
REQ-005 SHALL take parameter N_decisions, default 5; pairwise decisions per sample (N_classes-1).
REQ-006 SHALL derive localparam accWidth = inputWidth+weightWidth+clog2(N_features)+2.
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 clk  input  1  clock; all state changes on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 in_valid  input  1  new sample present on features.
REQ-011 features  input  inputWidth*N_features  unsigned features; feature i at bits [(i+1)*inputWidth-1 -: inputWidth].
REQ-012 weight  input  weightWidth*N_features  signed weight vector for the current decision, same packing; driven combinationally by the picker.
REQ-013 bia  input  biasWidth  signed bias for the current decision.
REQ-014 busy  output  1  sample in progress.
REQ-015 svmready  output  1  one-cycle pulse: decision result valid.
REQ-016 w_class  output  1  decision result; valid only while svmready=1.

Function
REQ-017 SHALL implement states IDLE, MAC, DONE.
REQ-018 IDLE: busy=0; in_valid=1 latches features into an internal register, clears idx, loads acc with sign-extended bia, clears the decision counter, and moves to MAC.
REQ-019 MAC: each cycle acc += signed({1'b0,feature[idx]}) * signed(weight[idx]); idx increments; after idx=N_features-1 moves to DONE.
REQ-020 On leaving MAC, w_class SHALL be registered as 1 iff the final signed score (acc incl. that cycle's product) >= 0, else 0.
REQ-021 DONE: svmready=1 for exactly one cycle; the decision counter increments.
REQ-022 From DONE, if the counter has reached N_decisions, the block moves to IDLE; otherwise it moves to MAC with idx=0 and acc reloaded with sign-extended bia sampled that same DONE-exit edge.
REQ-023 The acc reload on the DONE-exit edge SHALL sample bia/weight as driven after the picker's state update, i.e. the picker state changes at the edge that ends DONE.
REQ-024 All arithmetic SHALL be signed at accWidth; no saturation; accWidth guarantees no overflow.
REQ-025 Latency: in_valid accepted at cycle T -> MAC T+1..T+N_features -> first svmready at T+N_features+1; subsequent pulses every N_features+1 cycles.
REQ-026 busy=1 from T+1 through the last DONE cycle inclusive; total N_decisions*(N_features+1) cycles.
REQ-027 in_valid while busy SHALL be ignored, including during the final DONE; the next sample is accepted no earlier than the first IDLE cycle.
REQ-028 Features change during busy SHALL NOT affect results (latched copy used).
REQ-029 w_class SHALL hold its last value outside svmready; consumers qualify with svmready.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, busy=0, svmready=0, w_class=0, acc=0, idx=0, decision counter=0, regardless of state.
REQ-031 Reset mid-MAC or during DONE SHALL abort the sample with no further svmready pulse.
REQ-032 in_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-033 Reset: hold rst 2 cycles with in_valid=1 -> busy=0, svmready=0, w_class=0 throughout and on the cycle after release.
REQ-034 Positive: features all 1, weights all +1, bia=0, in_valid at T -> svmready at T+5, w_class=1 (score 4).
REQ-035 Negative/boundary: weights all +1, features all 1, bia=-5 -> w_class=0 (score -1); bia=-4 -> w_class=1 (score 0).
REQ-036 Extreme: features all 15, weights all -128, bia=-2048 -> score -9728, w_class=0, no wrap.
REQ-037 Sequencing: one sample -> exactly 5 svmready pulses at T+5, T+10, ..., T+25; busy falls at T+26; in_valid pulsed at T+12 and T+25 ignored; in_valid at T+26 starts a new sample.
REQ-038 Abort: rst asserted at T+3 -> no svmready until a new in_valid; new sample then completes with correct results.
